// File: rtl/msrv_32_ahb_dmem_slave_if.sv
// AHB-Lite data-bus bundle between the core (master) and the data-memory responder (slave).
interface msrv_32_ahb_dmem_slave_if;
  logic [31:0] haddr_in;
  logic [1:0]  htrans_in;
  logic        hwrite_in;
  logic [3:0]  hwmask_in;
  logic [31:0] hwdata_in;
  logic [31:0] hrdata_out;
  logic        hready_out;
  logic        hresp_out;

  modport master (
    output haddr_in, htrans_in, hwrite_in, hwmask_in, hwdata_in,
    input  hrdata_out, hready_out, hresp_out
  );

  modport slave (
    input  haddr_in, htrans_in, hwrite_in, hwmask_in, hwdata_in,
    output hrdata_out, hready_out, hresp_out
  );
endinterface

// File: rtl/msrv_32_ahb_dmem_slave.sv
// AHB-Lite word-organised data RAM with byte-lane writes and a two-cycle ERROR response.
// Wait-state insertion is built only when MSRV32_DMEM_WAIT_EN is defined.
module msrv_32_ahb_dmem_slave #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                      ms_risc32_mp_clk_in,
  input  logic                      ms_risc32_mp_rst_in,
  msrv_32_ahb_dmem_slave_if.slave   bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned AW    = DEPTH_LOG2 + 2;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] DATA = 3'd1;
  localparam logic [2:0] ERR1 = 3'd3;
  localparam logic [2:0] ERR2 = 3'd4;

`ifdef MSRV32_DMEM_WAIT_EN
  localparam logic [2:0] WAIT      = 3'd2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  logic [3:0] cnt_q, cnt_d;
`else
  localparam bit unused_wait_cycles = (WAIT_CYCLES != 0);
`endif

  logic [2:0]            state_q, state_d;
  logic [31:0]           addr_q, addr_d;
  logic                  write_q, write_d;
  logic [3:0]            mask_q, mask_d;
  logic [31:0]           mem [DEPTH];
  logic [31:0]           offset;
  logic [DEPTH_LOG2-1:0] word;
  logic                  hready, accept, addr_err;
  logic                  unused_offset_bits;

  assign hready   = (state_q == IDLE) || (state_q == DATA) || (state_q == ERR2);
  assign accept   = hready && bus.htrans_in[1];
  // BASE_ADDR is aligned to the RAM size, so range checking is an upper-bit compare.
  assign addr_err = bus.haddr_in[31:AW] != BASE_ADDR[31:AW];

  assign offset             = addr_q - BASE_ADDR;
  assign word               = offset[AW-1:2];
  assign unused_offset_bits = ^{offset[31:AW], offset[1:0]};

  // NOTE: every variable assigned here gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    mask_d  = mask_q;
`ifdef MSRV32_DMEM_WAIT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE, DATA, ERR2: begin
        state_d = IDLE;
        if (accept) begin
          addr_d  = bus.haddr_in;
          write_d = bus.hwrite_in;
          mask_d  = bus.hwmask_in;
          if (addr_err) begin
            state_d = ERR1;
`ifdef MSRV32_DMEM_WAIT_EN
          end else if (WAIT_INIT != 4'd0) begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
`endif
          end else begin
            state_d = DATA;
          end
        end
      end
`ifdef MSRV32_DMEM_WAIT_EN
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = DATA;
      end
`endif
      ERR1:    state_d = ERR2;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge ms_risc32_mp_clk_in) begin
    if (ms_risc32_mp_rst_in) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      mask_q  <= '0;
`ifdef MSRV32_DMEM_WAIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      mask_q  <= mask_d;
`ifdef MSRV32_DMEM_WAIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // NOTE: the RAM array has no reset; a reset edge only blocks a pending commit.
  always_ff @(posedge ms_risc32_mp_clk_in) begin
    if (!ms_risc32_mp_rst_in && state_q == DATA && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_q[i]) mem[word][8*i +: 8] <= bus.hwdata_in[8*i +: 8];
      end
    end
  end

  assign bus.hready_out = hready;
  assign bus.hresp_out  = (state_q == ERR1) || (state_q == ERR2);
  assign bus.hrdata_out = (state_q == DATA && !write_q) ? mem[word] : 32'h0;

endmodule

// File: tb/tb_msrv_32_ahb_dmem_slave.sv
// Directed bench for msrv_32_ahb_dmem_slave: reset, masked writes, back-to-back access,
// error response, reset abort, and wait states when MSRV32_DMEM_WAIT_EN is defined.
module tb_msrv_32_ahb_dmem_slave;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  msrv_32_ahb_dmem_slave_if bus ();

  msrv_32_ahb_dmem_slave dut (
    .ms_risc32_mp_clk_in (clk),
    .ms_risc32_mp_rst_in (rst),
    .bus                 (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (bus.hready_out !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, 32'(bus.hready_out), 32'd1);
  endtask

  task automatic ahb_write(input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
    bus.haddr_in  = addr;
    bus.hwrite_in = 1'b1;
    bus.hwmask_in = mask;
    bus.htrans_in = 2'b10;
    tick();
    bus.htrans_in = 2'b00;
    bus.hwdata_in = data;
    wait_ready("wr");
    check("wr_resp", 32'(bus.hresp_out), 32'd0);
    tick();
  endtask

  task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
    bus.haddr_in  = addr;
    bus.hwrite_in = 1'b0;
    bus.htrans_in = 2'b10;
    tick();
    bus.htrans_in = 2'b00;
    wait_ready("rd");
    data = bus.hrdata_out;
    check("rd_resp", 32'(bus.hresp_out), 32'd0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    bus.haddr_in  = '0;
    bus.htrans_in = 2'b00;
    bus.hwrite_in = 1'b0;
    bus.hwmask_in = '0;
    bus.hwdata_in = '0;

    // Reset held two cycles, then one IDLE cycle and one BUSY cycle.
    tick();
    tick();
    check("rst_hready", 32'(bus.hready_out), 32'd1);
    check("rst_hresp",  32'(bus.hresp_out),  32'd0);
    check("rst_hrdata", bus.hrdata_out,      32'h0);
    rst = 1'b0;
    tick();
    check("idle_hready", 32'(bus.hready_out), 32'd1);
    check("idle_hresp",  32'(bus.hresp_out),  32'd0);
    check("idle_hrdata", bus.hrdata_out,      32'h0);
    bus.htrans_in = 2'b01;
    tick();
    check("busy_hready", 32'(bus.hready_out), 32'd1);
    check("busy_hresp",  32'(bus.hresp_out),  32'd0);
    bus.htrans_in = 2'b00;

`ifndef MSRV32_DMEM_WAIT_EN
    // Write 0x10 immediately followed by a read of the same word.
    bus.haddr_in  = 32'h10;
    bus.hwrite_in = 1'b1;
    bus.hwmask_in = 4'hF;
    bus.htrans_in = 2'b10;
    tick();
    check("b2b_wr_hready", 32'(bus.hready_out), 32'd1);
    bus.hwdata_in = 32'hDEAD_BEEF;
    bus.hwrite_in = 1'b0;
    tick();
    check("b2b_rd_hready", 32'(bus.hready_out), 32'd1);
    check("b2b_rd_hresp",  32'(bus.hresp_out),  32'd0);
    check("b2b_rd_data",   bus.hrdata_out,      32'hDEAD_BEEF);
    bus.htrans_in = 2'b00;
    tick();
    check("b2b_idle_data", bus.hrdata_out, 32'h0);
`else
    // Two wait states per data phase; the next address is held through them.
    ahb_write(32'h4,  4'hF, 32'h0404_0404);
    ahb_write(32'h10, 4'hF, 32'h1010_1010);
    bus.haddr_in  = 32'h4;
    bus.hwrite_in = 1'b0;
    bus.htrans_in = 2'b10;
    tick();
    check("ws_w1_hready", 32'(bus.hready_out), 32'd0);
    bus.haddr_in = 32'h10;
    tick();
    check("ws_w2_hready", 32'(bus.hready_out), 32'd0);
    check("ws_w2_hrdata", bus.hrdata_out,      32'h0);
    tick();
    check("ws_data_hready", 32'(bus.hready_out), 32'd1);
    check("ws_data_hrdata", bus.hrdata_out,      32'h0404_0404);
    tick();
    check("ws_next_hready", 32'(bus.hready_out), 32'd0);
    bus.htrans_in = 2'b00;
    wait_ready("ws_next");
    check("ws_next_hrdata", bus.hrdata_out, 32'h1010_1010);
    tick();
`endif

    // Byte-lane masked writes and a zero-mask write.
    ahb_write(32'h20, 4'hF,    32'h1122_3344);
    ahb_write(32'h20, 4'b0100, 32'h00AA_0000);
    ahb_read(32'h20, rd);
    check("mask_lane2", rd, 32'h11AA_3344);
    ahb_write(32'h20, 4'b1001, 32'h5500_0066);
    ahb_read(32'h20, rd);
    check("mask_lane03", rd, 32'h55AA_3366);
    ahb_write(32'h20, 4'b0000, 32'hFFFF_FFFF);
    ahb_read(32'h20, rd);
    check("mask_none", rd, 32'h55AA_3366);

    // Out-of-range read, then an out-of-range write accepted in ERR2.
    ahb_write(32'h0, 4'hF, 32'hCAFE_F00D);
    bus.haddr_in  = 32'h1000;
    bus.hwrite_in = 1'b0;
    bus.htrans_in = 2'b10;
    tick();
    check("err1_hready", 32'(bus.hready_out), 32'd0);
    check("err1_hresp",  32'(bus.hresp_out),  32'd1);
    check("err1_hrdata", bus.hrdata_out,      32'h0);
    bus.hwrite_in = 1'b1;
    bus.hwmask_in = 4'hF;
    tick();
    check("err2_hready", 32'(bus.hready_out), 32'd1);
    check("err2_hresp",  32'(bus.hresp_out),  32'd1);
    tick();
    check("werr1_hready", 32'(bus.hready_out), 32'd0);
    check("werr1_hresp",  32'(bus.hresp_out),  32'd1);
    bus.hwdata_in = 32'h1234_5678;
    bus.htrans_in = 2'b00;
    tick();
    check("werr2_hresp", 32'(bus.hresp_out), 32'd1);
    tick();
    check("err_done_hresp",  32'(bus.hresp_out),  32'd0);
    check("err_done_hready", 32'(bus.hready_out), 32'd1);
    ahb_read(32'h0, rd);
    check("err_no_write", rd, 32'hCAFE_F00D);

    // Reset during an in-flight write to 0x8 drops the write.
    ahb_write(32'h8, 4'hF, 32'hAAAA_5555);
    bus.haddr_in  = 32'h8;
    bus.hwrite_in = 1'b1;
    bus.hwmask_in = 4'hF;
    bus.htrans_in = 2'b10;
    tick();
    bus.htrans_in = 2'b00;
    bus.hwdata_in = 32'h0000_0000;
    rst = 1'b1;
    tick();
    check("abort_hready", 32'(bus.hready_out), 32'd1);
    check("abort_hresp",  32'(bus.hresp_out),  32'd0);
    rst = 1'b0;
    tick();
    ahb_read(32'h8, rd);
    check("abort_keep", rd, 32'hAAAA_5555);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
